five_stage_fetch_unit: RTL and testbench
========================================

Name: five_stage_fetch_unit

Overview:
- Fetch stage of the five-stage core; sits directly upstream of the decode-stage control unit.
- Owns the issue PC and issues address-tagged requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with inst_valid.
- Consumes next_PC_sel, target_PC, i_mem_read and stall_decode from the control unit; drops stale responses after a redirect by address match.

Parameters:
- CORE, 0, core index used in scan output
- ADDRESS_BITS, 20, PC / instruction address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC loaded on reset
- BUFFER_DEPTH, 2, instruction FIFO entries; power of two, at least 2
- SCAN_CYCLES_MIN, 0, first cycle of scan printing
- SCAN_CYCLES_MAX, 1000, last cycle of scan printing

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- next_PC_sel  in  2  2'b00 = sequential; any non-zero value = redirect to target_PC
- target_PC  in  ADDRESS_BITS  redirect address
- i_mem_read  in  1  fetch enable; 0 suppresses new requests
- stall_decode  in  1  decode is holding; do not pop the FIFO
- fetch_request  out  1  request valid to instruction memory
- fetch_address_out  out  ADDRESS_BITS  request address; always equals issue_PC
- fetch_ready  in  1  memory accepts the request this cycle
- fetch_valid  in  1  response valid
- fetch_address_in  in  ADDRESS_BITS  address tag of the response
- fetch_data_in  in  DATA_WIDTH  response instruction
- instruction  out  DATA_WIDTH  FIFO head data; 32'h00000013 (NOP) when empty
- inst_PC  out  ADDRESS_BITS  FIFO head address; expected_PC when empty
- inst_valid  out  1  FIFO non-empty
- issue_PC  out  ADDRESS_BITS  next address to be requested
- scan  in  1  enables the $display trace

Behaviour:
- Internal state:
  - issue_PC
  - expected_PC: address of the next in-order response
  - outstanding counter, 0..BUFFER_DEPTH
  - FIFO of {address, data}, BUFFER_DEPTH entries
- Reset (synchronous):
  - issue_PC = expected_PC = RESET_PC
  - FIFO empty, outstanding = 0
  - While reset is high: inst_valid = 0, fetch_request = 0
- redirect = (next_PC_sel != 2'b00).
- pop = inst_valid & ~stall_decode & ~redirect.
- fetch_request = i_mem_read & ~reset & ~redirect & (outstanding + occupancy - pop < BUFFER_DEPTH).
  - The pop term is combinational, so a steady stream with a 1-cycle memory sustains 1 instruction per cycle.
- Accept (fetch_request & fetch_ready): issue_PC <= issue_PC + 4, modulo 2^ADDRESS_BITS (wraps to 0); outstanding increments.
- Any response (fetch_valid) with outstanding > 0 decrements outstanding.
  - Accept and response in the same cycle leave the count unchanged.
  - A response while outstanding == 0 is ignored entirely.
- Push: fetch_valid & outstanding > 0 & ~redirect & (fetch_address_in == expected_PC).
  - Writes {fetch_address_in, fetch_data_in} to the FIFO tail.
  - expected_PC <= expected_PC + 4 (wraps).
  - A non-matching response is dropped silently.
- Push-to-visibility latency: 1 cycle; no combinational bypass from fetch_data_in to instruction.
- Simultaneous push and pop is allowed at any occupancy. The credit rule guarantees a push never hits a full FIFO; verification asserts this.
- Redirect cycle:
  - No request issued; no push; no pop.
  - Next cycle: issue_PC = expected_PC = target_PC, FIFO empty, inst_valid = 0.
  - outstanding keeps counting, so in-flight stale responses drain. They are dropped unless their tag equals the new expected_PC; data at that address is correct, so a match is accepted.
- Stall: FIFO head and all outputs hold while stall_decode = 1; fetching continues until credits run out.
- i_mem_read = 0: no new requests; in-flight responses are still accepted.
- Reset mid-operation: state reinitialised as above; late responses are absorbed by the outstanding == 0 rule.
- Scan: when scan is high and cycles lies in [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], print issue_PC, expected_PC, outstanding, occupancy, inst_valid and inst_PC each cycle.

Test Plan:
- Reset with RESET_PC = 0x100; 1-cycle memory; i_mem_read = 1, no stall:
  - fetch_address_out = 0x100, 0x104, 0x108 on consecutive cycles.
  - inst_valid rises 2 cycles after the first accept.
  - One instruction per cycle, inst_PC = 0x100, 0x104, …
- Hold stall_decode = 1 for 5 cycles mid-stream:
  - instruction and inst_PC hold.
  - fetch_request drops once outstanding + occupancy = 2.
  - After release, the stream resumes with no gap and no duplicate.
- Redirect with next_PC_sel = 2'b01, target_PC = 0x200, while 2 requests are in flight:
  - Next cycle inst_valid = 0.
  - Stale responses 0x108 and 0x10C are dropped.
  - First delivered inst_PC = 0x200.
- Response tag 0x300 while expected_PC = 0x104:
  - Dropped; outstanding decrements; FIFO unchanged.
- issue_PC = 0xFFFFC with ADDRESS_BITS = 20:
  - After accept, issue_PC = 0x00000; the response at 0xFFFFC is followed by 0x00000.
- Assert reset with 1 request outstanding, then return its response 1 cycle after reset deasserts:
  - Response ignored; issue_PC = RESET_PC; FIFO empty.

Source files
------------

// File: rtl/five_stage_fetch_unit.sv
// Instruction fetch stage: owns the issue PC, issues tagged requests, and queues
// in-order responses for decode. Stale responses after a redirect are dropped by tag match.
module five_stage_fetch_unit #(
  parameter int CORE            = 0,
  parameter int ADDRESS_BITS    = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int RESET_PC        = 0,
  parameter int BUFFER_DEPTH    = 2,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              next_PC_sel,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    i_mem_read,
  input  logic                    stall_decode,
  output logic                    fetch_request,
  output logic [ADDRESS_BITS-1:0] fetch_address_out,
  input  logic                    fetch_ready,
  input  logic                    fetch_valid,
  input  logic [ADDRESS_BITS-1:0] fetch_address_in,
  input  logic [DATA_WIDTH-1:0]   fetch_data_in,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    inst_valid,
  output logic [ADDRESS_BITS-1:0] issue_PC,
  input  logic                    scan
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);
  localparam int CNT_W = OCC_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [ADDRESS_BITS-1:0] expected_pc;
  logic [OCC_W-1:0]        outstanding;
  logic [OCC_W-1:0]        occupancy;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [ADDRESS_BITS-1:0] fifo_addr [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data [BUFFER_DEPTH];

  logic             redirect;
  logic             pop;
  logic             push;
  logic             accept;
  logic             resp_taken;
  logic [CNT_W-1:0] credits_used;

  assign redirect   = (next_PC_sel != 2'b00);
  assign inst_valid = ~reset & (occupancy != '0);
  assign pop        = inst_valid & ~stall_decode & ~redirect;

  // Counting the same-cycle pop as a freed slot lets a 1-cycle memory stream at full rate.
  assign credits_used  = CNT_W'(outstanding) + CNT_W'(occupancy) - CNT_W'(pop);
  assign fetch_request = i_mem_read & ~reset & ~redirect &
                         (credits_used < CNT_W'(BUFFER_DEPTH));
  assign accept        = fetch_request & fetch_ready;

  assign resp_taken = fetch_valid & (outstanding != '0);
  assign push       = resp_taken & ~redirect & (fetch_address_in == expected_pc);

  assign fetch_address_out = issue_PC;
  assign instruction       = inst_valid ? fifo_data[rd_ptr] : NOP;
  assign inst_PC           = inst_valid ? fifo_addr[rd_ptr] : expected_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_PC    <= ADDRESS_BITS'(RESET_PC);
      expected_pc <= ADDRESS_BITS'(RESET_PC);
      outstanding <= '0;
      occupancy   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      case ({accept, resp_taken})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (redirect) begin
        issue_PC    <= target_PC;
        expected_pc <= target_PC;
        occupancy   <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (accept) issue_PC <= issue_PC + ADDRESS_BITS'(4);
        if (push) begin
          expected_pc <= expected_pc + ADDRESS_BITS'(4);
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      occupancy <= occupancy + 1'b1;
        else if (pop && !push) occupancy <= occupancy - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= fetch_address_in;
      fifo_data[wr_ptr] <= fetch_data_in;
    end
  end

`ifndef SYNTHESIS
  int cycles;

  always_ff @(posedge clock) begin
    if (reset) cycles <= 0;
    else       cycles <= cycles + 1;
    if (!reset && push && !pop && occupancy == OCC_W'(BUFFER_DEPTH))
      $error("fetch unit %0d: push into full instruction FIFO", CORE);
    if (scan && cycles >= SCAN_CYCLES_MIN && cycles <= SCAN_CYCLES_MAX)
      $display("core %0d cycle %0d issue_PC %h expected_PC %h outstanding %0d occupancy %0d inst_valid %b inst_PC %h",
               CORE, cycles, issue_PC, expected_pc, outstanding, occupancy, inst_valid, inst_PC);
  end
`endif

endmodule

// File: tb/tb_five_stage_fetch_unit.sv
// Bench for five_stage_fetch_unit: directed scenarios plus a randomized stream
// checked against an in-order program-stream model with a tagged in-order memory.
module tb_five_stage_fetch_unit;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam logic [AW-1:0] RST = 20'h00100;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic          clock, reset, i_mem_read, stall_decode, fetch_ready, fetch_valid, scan;
  logic [1:0]    next_PC_sel;
  logic [AW-1:0] target_PC, fetch_address_in;
  logic [DW-1:0] fetch_data_in;
  logic          fetch_request, inst_valid;
  logic [AW-1:0] fetch_address_out, inst_PC, issue_PC;
  logic [DW-1:0] instruction;

  five_stage_fetch_unit #(
    .CORE(0), .ADDRESS_BITS(AW), .DATA_WIDTH(DW), .RESET_PC(32'h100),
    .BUFFER_DEPTH(2), .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock(clock), .reset(reset), .next_PC_sel(next_PC_sel), .target_PC(target_PC),
    .i_mem_read(i_mem_read), .stall_decode(stall_decode), .fetch_request(fetch_request),
    .fetch_address_out(fetch_address_out), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_address_in(fetch_address_in), .fetch_data_in(fetch_data_in),
    .instruction(instruction), .inst_PC(inst_PC), .inst_valid(inst_valid),
    .issue_PC(issue_PC), .scan(scan)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  typedef struct { logic [AW-1:0] addr; int rdy; } req_t;
  req_t mem_q[$];
  int   cyc, last_rdy, lat_max, resp_pct;
  bit   mem_auto;
  int   n_cmp, n_bad;

  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
    return {a[11:0], a} ^ 32'hC3A5_0F69;
  endfunction

  // One clock: record the accepted request, advance, then let the memory answer in order.
  task automatic tick();
    int r;
    #1;
    if (fetch_request && fetch_ready) begin
      r = cyc + $urandom_range(1, lat_max);
      if (r < last_rdy) r = last_rdy;
      last_rdy = r;
      mem_q.push_back('{fetch_address_out, r});
    end
    @(posedge clock);
    #1;
    cyc++;
    fetch_valid = 0;
    if (mem_auto && mem_q.size() > 0 && mem_q[0].rdy <= cyc &&
        $urandom_range(0, 99) < resp_pct) begin
      fetch_valid      = 1;
      fetch_address_in = mem_q[0].addr;
      fetch_data_in    = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  endtask

  task automatic respond();
    if (mem_q.size() > 0) begin
      fetch_valid      = 1;
      fetch_address_in = mem_q[0].addr;
      fetch_data_in    = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  endtask

  task automatic do_reset(input bit auto_mem);
    reset = 1; next_PC_sel = 0; fetch_valid = 0;
    mem_auto = auto_mem; lat_max = 1; resp_pct = 100;
    fetch_ready = 1; i_mem_read = 1; stall_decode = 0;
    tick(); tick();
    reset = 0;
    mem_q.delete(); last_rdy = 0; fetch_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; i_mem_read = 1; stall_decode = 0; next_PC_sel = 0; fetch_ready = 1;
    mem_auto = 1; lat_max = 1; resp_pct = 100;
    tick(); tick(); #1;
    n_cmp++; if (fetch_request !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", fetch_request); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    reset = 0; mem_q.delete(); last_rdy = 0; fetch_valid = 0; #1;
    n_cmp++; if (issue_PC !== RST) begin n_bad++; $display("FAIL rst_issue_pc: got %h want %h", issue_PC, RST); end
    n_cmp++; if (inst_PC !== RST) begin n_bad++; $display("FAIL rst_inst_pc: got %h want %h", inst_PC, RST); end
    n_cmp++; if (instruction !== NOP) begin n_bad++; $display("FAIL rst_nop: got %h want %h", instruction, NOP); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid_after: got %b want 0", inst_valid); end
  endtask

  task automatic test_stream();
    logic [AW-1:0] pc;
    do_reset(1);
    for (int k = 0; k < 12; k++) begin
      if (k < 3) begin
        pc = RST + AW'(4 * k);
        n_cmp++; if (fetch_request !== 1'b1 || fetch_address_out !== pc) begin
          n_bad++; $display("FAIL stream_req%0d: got %b/%h want 1/%h", k, fetch_request, fetch_address_out, pc); end
      end
      if (k < 2) begin
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early%0d: got %b want 0", k, inst_valid); end
      end else begin
        pc = RST + AW'(4 * (k - 2));
        n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== pc || instruction !== mem_word(pc)) begin
          n_bad++; $display("FAIL stream_inst%0d: got %b/%h/%h want 1/%h/%h", k, inst_valid, inst_PC, instruction, pc, mem_word(pc)); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] p, pc;
    do_reset(1);
    for (int k = 0; k < 6; k++) tick();
    p = RST + AW'(16);
    stall_decode = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== p || instruction !== mem_word(p)) begin
        n_bad++; $display("FAIL stall_hold%0d: got %b/%h/%h want 1/%h/%h", k, inst_valid, inst_PC, instruction, p, mem_word(p)); end
      n_cmp++; if (fetch_request !== 1'b0) begin n_bad++; $display("FAIL stall_req%0d: got %b want 0", k, fetch_request); end
      tick();
    end
    stall_decode = 0;
    for (int j = 0; j < 6; j++) begin
      #1;
      pc = p + AW'(4 * j);
      n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== pc || instruction !== mem_word(pc)) begin
        n_bad++; $display("FAIL stall_resume%0d: got %b/%h want 1/%h", j, inst_valid, inst_PC, pc); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset(0);
    stall_decode = 1;
    tick(); tick();
    respond(); tick();
    respond(); tick();
    stall_decode = 0;
    tick(); tick();
    #1;
    n_cmp++; if (mem_q.size() !== 2 || mem_q[0].addr !== 20'h00108 || mem_q[1].addr !== 20'h0010C) begin
      n_bad++; $display("FAIL redir_inflight: got %0d entries want 2 (108,10C)", mem_q.size()); end
    next_PC_sel = 2'b01; target_PC = 20'h00200; #1;
    n_cmp++; if (fetch_request !== 1'b0) begin n_bad++; $display("FAIL redir_req: got %b want 0", fetch_request); end
    tick();
    next_PC_sel = 2'b00; #1;
    n_cmp++; if (inst_valid !== 1'b0 || issue_PC !== 20'h00200 || inst_PC !== 20'h00200) begin
      n_bad++; $display("FAIL redir_next: got %b/%h/%h want 0/00200/00200", inst_valid, issue_PC, inst_PC); end
    respond(); tick();
    respond(); #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL redir_stale: got %b want 0", inst_valid); end
    tick();
    respond(); #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL redir_stale2: got %b want 0", inst_valid); end
    tick(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== 20'h00200 || instruction !== mem_word(20'h00200)) begin
      n_bad++; $display("FAIL redir_first: got %b/%h/%h want 1/00200/%h", inst_valid, inst_PC, instruction, mem_word(20'h00200)); end
  endtask

  task automatic test_bad_tag();
    do_reset(0);
    stall_decode = 1;
    tick(); tick();
    respond(); tick();
    void'(mem_q.pop_front());
    fetch_valid = 1; fetch_address_in = 20'h00300; fetch_data_in = 32'hDEAD_BEEF;
    tick(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== RST) begin
      n_bad++; $display("FAIL badtag_fifo: got %b/%h want 1/%h", inst_valid, inst_PC, RST); end
    n_cmp++; if (fetch_request !== 1'b1 || fetch_address_out !== 20'h00108) begin
      n_bad++; $display("FAIL badtag_credit: got %b/%h want 1/00108", fetch_request, fetch_address_out); end
    tick();
    stall_decode = 0; #1;
    n_cmp++; if (inst_PC !== RST) begin n_bad++; $display("FAIL badtag_head: got %h want %h", inst_PC, RST); end
    tick(); #1;
    n_cmp++; if (inst_valid !== 1'b0 || inst_PC !== 20'h00104) begin
      n_bad++; $display("FAIL badtag_expected: got %b/%h want 0/00104", inst_valid, inst_PC); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    next_PC_sel = 2'b10; target_PC = 20'hFFFFC; #1;
    tick();
    next_PC_sel = 2'b00; #1;
    n_cmp++; if (issue_PC !== 20'hFFFFC || fetch_address_out !== 20'hFFFFC) begin
      n_bad++; $display("FAIL wrap_target: got %h want FFFFC", issue_PC); end
    tick(); #1;
    n_cmp++; if (issue_PC !== 20'h00000) begin n_bad++; $display("FAIL wrap_issue: got %h want 00000", issue_PC); end
    tick(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== 20'hFFFFC || instruction !== mem_word(20'hFFFFC)) begin
      n_bad++; $display("FAIL wrap_top: got %b/%h want 1/FFFFC", inst_valid, inst_PC); end
    tick(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== 20'h00000 || instruction !== mem_word(20'h00000)) begin
      n_bad++; $display("FAIL wrap_zero: got %b/%h want 1/00000", inst_valid, inst_PC); end
  endtask

  task automatic test_reset_midop();
    do_reset(0);
    stall_decode = 1;
    tick();
    reset = 1; #1;
    n_cmp++; if (fetch_request !== 1'b0 || inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs: got %b/%b want 0/0", fetch_request, inst_valid); end
    tick();
    reset = 0; i_mem_read = 0;
    respond(); #1;
    n_cmp++; if (issue_PC !== RST) begin n_bad++; $display("FAIL midrst_issue: got %h want %h", issue_PC, RST); end
    tick();
    i_mem_read = 1; #1;
    n_cmp++; if (inst_valid !== 1'b0 || inst_PC !== RST || issue_PC !== RST) begin
      n_bad++; $display("FAIL midrst_state: got %b/%h/%h want 0/%h/%h", inst_valid, inst_PC, issue_PC, RST, RST); end
    n_cmp++; if (fetch_request !== 1'b1) begin n_bad++; $display("FAIL midrst_req: got %b want 1", fetch_request); end
  endtask

  task automatic test_random_stream();
    logic [AW-1:0] exp_pc;
    int pops;
    do_reset(1);
    lat_max = 3; resp_pct = 70;
    exp_pc = RST; pops = 0;
    for (int k = 0; k < 3000; k++) begin
      stall_decode = ($urandom_range(0, 3) == 0);
      fetch_ready  = ($urandom_range(0, 4) != 0);
      i_mem_read   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 39) == 0) begin
        next_PC_sel = 2'($urandom_range(1, 3));
        target_PC   = AW'($urandom) & ~AW'(3);
      end else begin
        next_PC_sel = 2'b00;
      end
      #1;
      if (next_PC_sel != 2'b00) begin
        exp_pc = target_PC;
      end else if (inst_valid && !stall_decode) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== mem_word(exp_pc)) begin
          n_bad++; $display("FAIL rand_pop%0d: got %h/%h want %h/%h", k, inst_PC, instruction, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + AW'(4);
        pops++;
      end
      tick();
    end
    next_PC_sel = 2'b00; stall_decode = 0; fetch_ready = 1; i_mem_read = 1;
    n_cmp++; if (pops < 300) begin n_bad++; $display("FAIL rand_throughput: got %0d pops want >= 300", pops); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; last_rdy = 0;
    reset = 1; next_PC_sel = 0; target_PC = '0; i_mem_read = 0; stall_decode = 0;
    fetch_ready = 0; fetch_valid = 0; fetch_address_in = '0; fetch_data_in = '0; scan = 0;
    mem_auto = 1; lat_max = 1; resp_pct = 100;
    @(posedge clock); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_bad_tag();
    test_wrap();
    test_reset_midop();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
